// File: rtl/alpha_sram_arb.sv
// Two-requester arbiter for a single-port alpha-metric SRAM with burst limiting.
// Optional stall statistics counter enabled by defining ALPHA_ARB_STATS_EN.
module alpha_sram_arb #(
   parameter int AW   = 8,
   parameter int DW   = 64,
   parameter int MAXB = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fwd_req,
   input  logic          fwd_w_r,
   input  logic [AW-1:0] fwd_addr,
   input  logic [DW-1:0] fwd_wdata,
   output logic          fwd_gnt,
   output logic          fwd_rvalid,
   input  logic          bwd_req,
   input  logic          bwd_w_r,
   input  logic [AW-1:0] bwd_addr,
   input  logic [DW-1:0] bwd_wdata,
   output logic          bwd_gnt,
   output logic          bwd_rvalid,
   output logic [DW-1:0] rdata,
   output logic          sram_en,
   output logic          sram_w_r,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_wdata,
   input  logic [DW-1:0] sram_rdata,
   output logic [15:0]   conflict_cnt
);

   localparam int             CW   = $clog2(MAXB + 1);
   localparam logic [CW-1:0]  BMAX = CW'(MAXB);

   typedef enum logic [1:0] {IDLE, GF, GB} state_t;

   state_t        state_q, state_d;
   logic          last_b_q, last_b_d;
   logic [CW-1:0] burst_q, burst_d, burst_inc;
   logic          rdy_q;
   logic          fwd_rv_q, bwd_rv_q;

   // rdy_q holds arbitration off for the first edge after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_b_q <= 1'b1;
         burst_q  <= '0;
         rdy_q    <= 1'b0;
         fwd_rv_q <= 1'b0;
         bwd_rv_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_b_q <= last_b_d;
         burst_q  <= burst_d;
         rdy_q    <= 1'b1;
         fwd_rv_q <= sram_en & ~sram_w_r & (state_q == GF);
         bwd_rv_q <= sram_en & ~sram_w_r & (state_q == GB);
      end
   end

   always_comb begin
      state_d   = state_q;
      burst_d   = burst_q;
      last_b_d  = last_b_q;
      burst_inc = (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            burst_d = '0;
            if (rdy_q) begin
               if (fwd_req && (!bwd_req || last_b_q)) state_d = GF;
               else if (bwd_req)                      state_d = GB;
            end
         end
         GF: begin
            if (!fwd_req) state_d = bwd_req ? GB : IDLE;
            else begin
               burst_d = burst_inc;
               if (burst_inc == BMAX && bwd_req) state_d = GB;
            end
         end
         GB: begin
            if (!bwd_req) state_d = fwd_req ? GF : IDLE;
            else begin
               burst_d = burst_inc;
               if (burst_inc == BMAX && fwd_req) state_d = GF;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) burst_d = '0;
      if (state_d == GF)      last_b_d = 1'b0;
      else if (state_d == GB) last_b_d = 1'b1;
   end

   always_comb begin
      sram_en    = 1'b0;
      sram_w_r   = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      unique case (state_q)
         GF: begin
            sram_en    = fwd_req;
            sram_w_r   = fwd_w_r;
            sram_addr  = fwd_addr;
            sram_wdata = fwd_wdata;
         end
         GB: begin
            sram_en    = bwd_req;
            sram_w_r   = bwd_w_r;
            sram_addr  = bwd_addr;
            sram_wdata = bwd_wdata;
         end
         default: ;
      endcase
   end

   assign fwd_gnt    = (state_q == GF);
   assign bwd_gnt    = (state_q == GB);
   assign fwd_rvalid = fwd_rv_q;
   assign bwd_rvalid = bwd_rv_q;
   assign rdata      = sram_rdata;

`ifdef ALPHA_ARB_STATS_EN
   logic [15:0] cc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cc_q <= '0;
      else if (((fwd_req & ~fwd_gnt) | (bwd_req & ~bwd_gnt)) && cc_q != 16'hFFFF)
         cc_q <= cc_q + 16'd1;
   end

   assign conflict_cnt = cc_q;
`else
   assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alpha_sram_arb.sv
// Bench for alpha_sram_arb: directed scenarios plus randomized traffic against a
// transaction-level arbitration/SRAM model.
module tb_alpha_sram_arb;

   localparam int AW = 8, DW = 64, MAXB = 8;

   logic          clk = 1'b0, rst;
   logic          fwd_req, fwd_w_r, bwd_req, bwd_w_r;
   logic [AW-1:0] fwd_addr, bwd_addr;
   logic [DW-1:0] fwd_wdata, bwd_wdata;
   logic          fwd_gnt, fwd_rvalid, bwd_gnt, bwd_rvalid;
   logic [DW-1:0] rdata, sram_wdata, sram_rdata;
   logic          sram_en, sram_w_r;
   logic [AW-1:0] sram_addr;
   logic [15:0]   conflict_cnt;

   int total = 0, bad = 0;

   alpha_sram_arb #(.AW(AW), .DW(DW), .MAXB(MAXB)) dut (
      .clk(clk), .rst(rst),
      .fwd_req(fwd_req), .fwd_w_r(fwd_w_r), .fwd_addr(fwd_addr), .fwd_wdata(fwd_wdata),
      .fwd_gnt(fwd_gnt), .fwd_rvalid(fwd_rvalid),
      .bwd_req(bwd_req), .bwd_w_r(bwd_w_r), .bwd_addr(bwd_addr), .bwd_wdata(bwd_wdata),
      .bwd_gnt(bwd_gnt), .bwd_rvalid(bwd_rvalid),
      .rdata(rdata),
      .sram_en(sram_en), .sram_w_r(sram_w_r), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // behavioural single-port SRAM
   logic [DW-1:0] sram_mem [256];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_w_r) sram_mem[sram_addr] <= sram_wdata;
         else          sram_rdata <= sram_mem[sram_addr];
      end
   end

   // reference model: owner 0=none 1=fwd 2=bwd
   int            m_own, m_last, m_run, m_rv, m_cc;
   bit            m_rdy, f_hold, b_hold;
   logic [DW-1:0] m_mem [256];
   logic [DW-1:0] m_rdata;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_own = 0; m_last = 2; m_run = 0; m_rv = 0; m_cc = 0; m_rdy = 0;
      f_hold = 0; b_hold = 0;
   endtask

   function automatic logic [15:0] exp_cc();
`ifdef ALPHA_ARB_STATS_EN
      return 16'(m_cc);
`else
      return 16'd0;
`endif
   endfunction

   // compare outputs for the current cycle, then advance model across one edge
   task automatic step();
      bit            req [3];
      bit            o_en, o_w;
      logic [AW-1:0] o_a;
      logic [DW-1:0] o_d;
      int            nxt, oth;
      req[0] = 0; req[1] = fwd_req; req[2] = bwd_req;
      o_en = 0; o_w = 0; o_a = '0; o_d = '0;
      if (m_own == 1) begin o_en = fwd_req; o_w = fwd_w_r; o_a = fwd_addr; o_d = fwd_wdata; end
      if (m_own == 2) begin o_en = bwd_req; o_w = bwd_w_r; o_a = bwd_addr; o_d = bwd_wdata; end
      #1;
      chk("fwd_gnt", fwd_gnt, m_own == 1);
      chk("bwd_gnt", bwd_gnt, m_own == 2);
      chk("sram_en", sram_en, o_en);
      chk("sram_w_r", sram_w_r, o_w);
      chk("sram_addr", sram_addr, o_a);
      chk("sram_wdata", sram_wdata, o_d);
      chk("fwd_rvalid", fwd_rvalid, m_rv == 1);
      chk("bwd_rvalid", bwd_rvalid, m_rv == 2);
      chk("rv_excl", fwd_rvalid & bwd_rvalid, 0);
      if (m_rv != 0) chk("rdata", rdata, m_rdata);
      chk("conflict_cnt", conflict_cnt, exp_cc());
      @(posedge clk);
      f_hold = fwd_req && m_own != 1;
      b_hold = bwd_req && m_own != 2;
      if ((f_hold || b_hold) && m_cc < 65535) m_cc++;
      m_rv = 0;
      if (o_en) begin
         if (o_w) m_mem[o_a] = o_d;
         else begin m_rv = m_own; m_rdata = m_mem[o_a]; end
      end
      nxt = m_own;
      if (!m_rdy) m_rdy = 1;
      else if (m_own == 0) begin
         if (req[1] && req[2]) nxt = (m_last == 2) ? 1 : 2;
         else if (req[1])      nxt = 1;
         else if (req[2])      nxt = 2;
      end else begin
         oth = 3 - m_own;
         if (!req[m_own]) nxt = req[oth] ? oth : 0;
         else begin
            if (m_run < MAXB) m_run++;
            if (m_run == MAXB && req[oth]) nxt = oth;
         end
      end
      if (nxt != m_own || nxt == 0) m_run = 0;
      if (nxt != 0) m_last = nxt;
      m_own = nxt;
      @(negedge clk);
   endtask

   task automatic clr_req();
      fwd_req = 0; fwd_w_r = 0; fwd_addr = '0; fwd_wdata = '0;
      bwd_req = 0; bwd_w_r = 0; bwd_addr = '0; bwd_wdata = '0;
   endtask

   // reset then one quiet cycle so the arbiter is ready at "cycle 0"
   task automatic do_reset();
      rst = 1; clr_req();
      @(negedge clk);
      rst = 0; m_reset();
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin sram_mem[i] = '0; m_mem[i] = '0; end
      sram_rdata = '0;
      rst = 1; clr_req(); m_reset();
      @(negedge clk); #1;
      chk("rst_fwd_gnt", fwd_gnt, 0);
      chk("rst_bwd_gnt", bwd_gnt, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_rvalid", {fwd_rvalid, bwd_rvalid}, 0);
      chk("rst_cc", conflict_cnt, 0);

      // first grant not before the second edge after reset release
      fwd_req = 1; fwd_w_r = 1; fwd_addr = 8'd3; fwd_wdata = 64'h33;
      @(negedge clk);
      rst = 0; m_reset();
      step(); #1 chk("holdoff_gnt", fwd_gnt, 0);
      step(); #1 chk("first_gnt", fwd_gnt, 1);
      step();
      fwd_req = 0; step();

      // forward-only: writes to 0,8,..,56
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         fwd_req = 1; fwd_w_r = 1;
         fwd_addr = (k == 0) ? 8'd0 : 8'(8 * (k - 1));
         fwd_wdata = 64'hF00 + 64'(fwd_addr);
         #1;
         chk("fo_gnt", fwd_gnt, k >= 1);
         chk("fo_en", sram_en, k >= 1);
         if (k >= 1) chk("fo_addr", sram_addr, 8 * (k - 1));
         chk("fo_bgnt", bwd_gnt, 0);
         step();
      end
      fwd_req = 0; step(); step();

      // tie from idle then burst-limited alternation F8,B8,F4
      do_reset();
      fwd_w_r = 1; fwd_addr = 8'd100; fwd_wdata = 64'hAAAA;
      bwd_w_r = 1; bwd_addr = 8'd101; bwd_wdata = 64'hBBBB;
      for (int k = 0; k <= 20; k++) begin
         fwd_req = 1; bwd_req = 1;
         #1;
         chk("bl_fgnt", fwd_gnt, (k >= 1 && k <= 8) || k >= 17);
         chk("bl_bgnt", bwd_gnt, k >= 9 && k <= 16);
         step();
      end
      clr_req(); #1;
`ifdef ALPHA_ARB_STATS_EN
      chk("bl_cc", conflict_cnt, 21);
`else
      chk("bl_cc", conflict_cnt, 0);
`endif
      step();

      // read latency across a burst-limit hand-over
      do_reset();
      bwd_req = 1; bwd_w_r = 1; bwd_addr = 8'd8; bwd_wdata = 64'hC0FFEE_0008;
      step(); step();
      fwd_req = 1; fwd_w_r = 0; fwd_addr = 8'd0;
      for (int k = 2; k <= 7; k++) begin
         bwd_addr = 8'(16 + k); bwd_wdata = 64'(k);
         step();
      end
      bwd_w_r = 0; bwd_addr = 8'd8;
      step();
      bwd_req = 0; #1;
      chk("rl_brv", bwd_rvalid, 1);
      chk("rl_rdata", rdata, 64'hC0FFEE_0008);
      chk("rl_frv", fwd_rvalid, 0);
      chk("rl_fgnt", fwd_gnt, 1);
      step();
      fwd_req = 0; step(); step();

      // async reset during a forward read
      do_reset();
      fwd_req = 1; fwd_w_r = 0; fwd_addr = 8'd8;
      step(); #1;
      chk("ar_pre_en", sram_en, 1);
      #2 rst = 1; #1;
      chk("ar_fgnt", fwd_gnt, 0);
      chk("ar_en", sram_en, 0);
      chk("ar_rv", {fwd_rvalid, bwd_rvalid}, 0);
      @(posedge clk); #1;
      chk("ar_rv_next", fwd_rvalid, 0);
      chk("ar_idle", {fwd_gnt, bwd_gnt}, 0);
      @(negedge clk);
      clr_req(); rst = 0; m_reset();
      step();

      // randomized traffic; stalled requesters hold their fields
      for (int n = 0; n < 3000; n++) begin
         if (!f_hold) begin
            fwd_req = ($urandom_range(0, 3) != 0); fwd_w_r = 1'($urandom_range(0, 1));
            fwd_addr = 8'($urandom_range(0, 31)); fwd_wdata = {$urandom, $urandom};
         end
         if (!b_hold) begin
            bwd_req = ($urandom_range(0, 3) != 0); bwd_w_r = 1'($urandom_range(0, 1));
            bwd_addr = 8'($urandom_range(0, 31)); bwd_wdata = {$urandom, $urandom};
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alpha_sram_arb.md
ALPHA_SRAM_ARB -- requirements
Module: alpha_sram_arb

Interface
REQ-001 Parameters SHALL be: AW, default 8, SRAM address width; DW, default 64, alpha word width (8 states x 8 bit); MAXB, default 8, burst limit in granted cycles.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 fwd_req / fwd_w_r / fwd_addr / fwd_wdata  in  1/1/AW/DW  forward-recursion request, 1=write 0=read, address, write data.
REQ-005 fwd_gnt / fwd_rvalid  out  1/1  forward grant; forward read data valid.
REQ-006 bwd_req / bwd_w_r / bwd_addr / bwd_wdata  in  1/1/AW/DW  backward/LLR requester, same meaning.
REQ-007 bwd_gnt / bwd_rvalid  out  1/1  backward grant; backward read data valid.
REQ-008 rdata  out  DW  read data, driven directly from sram_rdata.
REQ-009 sram_en / sram_w_r / sram_addr / sram_wdata  out  1/1/AW/DW  single-port alpha SRAM command.
REQ-010 sram_rdata  in  DW  SRAM read data, valid one cycle after read command.
REQ-011 conflict_cnt  out  16  stalled-request cycle count (see Configuration).

Function
REQ-012 FSM SHALL have states IDLE, GF (forward owns port), GB (backward owns port); fwd_gnt=1 only in GF, bwd_gnt=1 only in GB, both registered.
REQ-013 IDLE: fwd_req only -> GF; bwd_req only -> GB; both -> side not granted last (last-owner flag, reset value = backward, so forward wins first tie); none -> IDLE.
REQ-014 GF/GB: owner req=0 -> other side if its req=1, else IDLE; state change takes effect next cycle, no dead cycle on hand-over.
REQ-015 Burst counter SHALL count granted cycles with owner req=1; at MAXB consecutive cycles with the other req=1, grant SHALL move to the other side next cycle and counter clear; with other req=0 owner keeps grant and counter holds at MAXB.
REQ-016 Counter SHALL clear on every grant change and in IDLE.
REQ-017 SRAM command SHALL be combinational from state: sram_en = owner gnt & owner req; sram_w_r, sram_addr, sram_wdata muxed from owner; in IDLE sram_en=0, other outputs 0.
REQ-018 A requester's transfer completes in any cycle where its gnt=1 and req=1; requester holds fields stable while req=1 and gnt=0.
REQ-019 Read with sram_en=1, sram_w_r=0 at cycle n SHALL assert owner's rvalid for exactly cycle n+1, even if grant switched at n+1.
REQ-020 fwd_rvalid and bwd_rvalid SHALL never be 1 together; writes never raise rvalid.
REQ-021 Requests arriving in the same cycle as a hand-over SHALL be arbitrated by REQ-013/014 next edge; no request dropped while req held.

Reset
REQ-022 rst=1 SHALL immediately (without clk) force state IDLE, fwd_gnt=bwd_gnt=0, fwd_rvalid=bwd_rvalid=0, burst counter 0, last-owner=backward, conflict_cnt=0, hence sram_en=0.
REQ-023 Reset during a burst SHALL abort it; a read issued in the cycle before reset SHALL produce no rvalid.
REQ-024 After rst falls, first grant SHALL appear no earlier than the second rising edge.

Configuration
REQ-025 Macro ALPHA_ARB_STATS_EN defined: conflict_cnt increments by 1 each cycle where (fwd_req & !fwd_gnt) | (bwd_req & !bwd_gnt), both-stalled counts 1, saturates at 16'hFFFF.
REQ-026 Macro undefined: conflict_cnt tied to 16'd0, no counter logic; all other behaviour identical.

Verification
REQ-027 Forward-only: fwd_req writes addr 0,8,..,56 (8 cycles) -> fwd_gnt from cycle 1, 8 sram writes in order, no rvalid, bwd_gnt=0.
REQ-028 Tie from IDLE after reset: both req at cycle 0 -> fwd_gnt at cycle 1; after fwd drops, bwd_gnt next cycle with no gap.
REQ-029 Burst limit: both hold req 20 cycles -> grants alternate in blocks of 8 (F8,B8,F4...); conflict_cnt (stats build) = cycles stalled, matches model.
REQ-030 Read latency: bwd read addr 8 granted at n -> bwd_rvalid only at n+1, rdata=SRAM word 8; fwd_rvalid stays 0 across a hand-over at n+1.
REQ-031 Async reset mid-burst: rst pulsed between edges during GF read -> gnts, sram_en, rvalid 0 at once, no rvalid next edge, state IDLE.
REQ-032 Stats off: same as REQ-029 without ALPHA_ARB_STATS_EN -> conflict_cnt constantly 0, grant sequence identical.
